// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback path.
//   WbEntry      : one queued multi-cycle result (destination + data)
//   reg_onehot() : one-hot mask for a register index, used by the pending scoreboard
package regfile_wb_arbiter_pkg;

    localparam int XLEN     = 64;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } WbEntry;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: small circular FIFO holding multi-cycle writeback results.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (drops all entries)
//   push        : enqueue push_entry at the clock edge (ignored when full)
//   push_entry  : WbEntry payload to enqueue
//   pop         : dequeue the head at the clock edge (ignored when empty)
//   head        : current head entry (valid when count != 0)
//   count       : occupancy, 0..DEPTH
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  WbEntry                   push_entry,
    input  logic                     pop,
    output WbEntry                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    WbEntry        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; fullness and
    // emptiness come from count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: an entry is only observed after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges in-order pipeline writebacks with queued
// multi-cycle results onto the register file's single write port, keeps the
// per-register pending mask for the hazard unit and requests a bubble when
// queued results are starved by back-to-back pipeline writes.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   pipe_we, pipe_rd, pipe_data      : pipeline writeback (highest priority)
//   mc_valid, mc_ready, mc_rd, mc_data : multi-cycle result handshake into FIFO
//   iss_mark, iss_rd                 : multi-cycle op issued, marks rd pending
//   we, write_addr, write_data       : register file write port
//   pend                             : pending mask, bit 0 tied low
//   wb_stall                         : pipeline bubble request
//   fifo_count                       : FIFO occupancy
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipe_we,
    input  logic [4:0]             pipe_rd,
    input  logic [63:0]            pipe_data,
    input  logic                   mc_valid,
    output logic                   mc_ready,
    input  logic [4:0]             mc_rd,
    input  logic [63:0]            mc_data,
    input  logic                   iss_mark,
    input  logic [4:0]             iss_rd,
    output logic                   we,
    output logic [4:0]             write_addr,
    output logic [63:0]            write_data,
    output logic [31:0]            pend,
    output logic                   wb_stall,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    WbEntry        head;
    WbEntry        push_entry;
    logic          pipe_live;
    logic          fifo_empty;
    logic          drain;
    logic          push;
    logic [31:0]   pend_q;
    logic [31:0]   pend_nxt;
    logic [SW-1:0] starve_left;
    logic [SW-1:0] starve_nxt;

    // Gating with rst_n keeps the write port quiet while reset is held, even
    // if the pipeline is still presenting a write.
    assign pipe_live  = rst_n && pipe_we && (pipe_rd != '0);
    assign fifo_empty = (fifo_count == '0);
    assign drain      = rst_n && !pipe_live && !fifo_empty;

    // Registered count only: a pop in the same cycle does not open a slot.
    assign mc_ready   = rst_n && (fifo_count < CW'(DEPTH));
    assign push       = mc_valid && mc_ready && (mc_rd != '0);
    assign push_entry = '{rd: mc_rd, data: mc_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head       (head),
        .count      (fifo_count)
    );

    always_comb begin
        we         = 1'b0;
        write_addr = '0;
        write_data = '0;
        if (pipe_live) begin
            we         = 1'b1;
            write_addr = pipe_rd;
            write_data = pipe_data;
        end else if (drain) begin
            we         = 1'b1;
            write_addr = head.rd;
            write_data = head.data;
        end
    end

    // Clear first, then set, so a re-issue to the draining register stays pending.
    always_comb begin
        pend_nxt = pend_q;
        if (drain)
            pend_nxt = pend_nxt & ~reg_onehot(head.rd);
        if (iss_mark && (iss_rd != '0))
            pend_nxt = pend_nxt | reg_onehot(iss_rd);
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_nxt;
    end

    assign pend = pend_q;

    // Starvation timer counts down the blocked cycles still tolerated; it is
    // reloaded on any drain or while the FIFO is empty and holds at zero.
    always_comb begin
        starve_nxt = starve_left;
        if (fifo_empty || drain)
            starve_nxt = SW'(STARVE_MAX);
        else if (starve_left != '0)
            starve_nxt = starve_left - SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_left <= SW'(STARVE_MAX);
        else        starve_left <= starve_nxt;
    end

    assign wb_stall = (starve_left == '0) && !fifo_empty;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [63:0] pipe_data = '0;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_rd = '0;
    logic [63:0] mc_data = '0;
    logic        iss_mark = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        we;
    logic [4:0]  write_addr;
    logic [63:0] write_data;
    logic [31:0] pend;
    logic        wb_stall;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard state: queued results expected to drain, pending mask, starve count.
    WbEntry      m_q[$];
    logic [31:0] m_pend = '0;
    int          m_starve = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .iss_mark   (iss_mark),
        .iss_rd     (iss_rd),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .pend       (pend),
        .wb_stall   (wb_stall),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected-state update at each edge: accepted results are pushed into the
    // queue, the head is popped when it drains.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_pend   = '0;
                m_starve = 0;
            end else begin
                logic live, drn, acc;
                int   sz;
                sz   = m_q.size();
                live = pipe_we && (pipe_rd != 0);
                drn  = !live && (sz > 0);
                acc  = mc_valid && (sz < DEPTH) && (mc_rd != 0);
                if (sz == 0 || drn)             m_starve = 0;
                else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
                if (drn) begin
                    m_pend[m_q[0].rd] = 1'b0;
                    void'(m_q.pop_front());
                end
                if (iss_mark && iss_rd != 0) m_pend[iss_rd] = 1'b1;
                if (acc) m_q.push_back('{rd: mc_rd, data: mc_data});
            end
        end
    end

    // Monitor: every cycle, compare the write port and status against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_we",     64'(we),         64'd0);
                check("rst_addr",   64'(write_addr), 64'd0);
                check("rst_data",   write_data,      64'd0);
                check("rst_ready",  64'(mc_ready),   64'd0);
                check("rst_stall",  64'(wb_stall),   64'd0);
                check("rst_pend",   64'(pend),       64'd0);
                check("rst_count",  64'(fifo_count), 64'd0);
            end else begin
                logic        live, e_we;
                logic [4:0]  e_addr;
                logic [63:0] e_data;
                live   = pipe_we && (pipe_rd != 0);
                e_we   = live || (m_q.size() > 0);
                e_addr = live ? pipe_rd   : (m_q.size() > 0 ? m_q[0].rd   : 5'd0);
                e_data = live ? pipe_data : (m_q.size() > 0 ? m_q[0].data : 64'd0);
                check("we",         64'(we),         64'(e_we));
                check("write_addr", 64'(write_addr), 64'(e_addr));
                check("write_data", write_data,      e_data);
                check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
                check("mc_ready",   64'(mc_ready),   64'(m_q.size() < DEPTH));
                check("pend",       64'(pend),       64'(m_pend));
                check("wb_stall",   64'(wb_stall),   64'((m_starve == STARVE_MAX) && (m_q.size() > 0)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        iss_mark = 0; iss_rd = 0;
    endtask

    initial begin
        // Reset state
        #1;
        check("init_we",    64'(we),       64'd0);
        check("init_ready", 64'(mc_ready), 64'd0);
        step(); step();
        rst_n = 1;
        @(negedge clk);
        check("post_rst_ready", 64'(mc_ready), 64'd1);

        // Mark x5, push its result, watch it write and clear pending
        step(); iss_mark = 1; iss_rd = 5;
        step(); idle(); mc_valid = 1; mc_rd = 5; mc_data = 64'hABCD;
        @(negedge clk);
        check("pend5_set", 64'(pend), 64'h20);
        step(); idle();
        @(negedge clk);
        check("mc_we",   64'(we),         64'd1);
        check("mc_addr", 64'(write_addr), 64'd5);
        check("mc_data", write_data,      64'hABCD);
        step();
        @(negedge clk);
        check("pend5_clr", 64'(pend), 64'h0);

        // Pipeline holds the port while four results queue up
        pipe_we = 1; pipe_rd = 3; pipe_data = 64'h33;
        for (int i = 0; i < 4; i++) begin
            mc_valid = 1; mc_rd = 5'(10 + i); mc_data = 64'h100 + 64'(i);
            step();
        end
        mc_rd = 20; mc_data = 64'h200;
        @(negedge clk);
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(mc_ready),   64'd0);
        check("full_stall", 64'(wb_stall),   64'd1);
        check("full_addr",  64'(write_addr), 64'd3);

        // Drop the pipeline: pop while full refuses the pending push
        step(); pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        @(negedge clk);
        check("pop_full_ready", 64'(mc_ready),   64'd0);
        check("pop_full_addr",  64'(write_addr), 64'd10);
        step();
        @(negedge clk);
        check("after_pop_ready", 64'(mc_ready),   64'd1);
        check("after_pop_count", 64'(fifo_count), 64'd3);
        check("after_pop_addr",  64'(write_addr), 64'd11);
        step(); idle();
        @(negedge clk);
        check("push_late_count", 64'(fifo_count), 64'd3);
        repeat (4) step();
        @(negedge clk);
        check("drained_count", 64'(fifo_count), 64'd0);

        // x0 targets: neither path writes, nothing queued
        step(); mc_valid = 1; mc_rd = 0; mc_data = 64'hDEAD;
        pipe_we = 1; pipe_rd = 0; pipe_data = 64'hBEEF;
        @(negedge clk);
        check("x0_we", 64'(we), 64'd0);
        step(); idle();
        @(negedge clk);
        check("x0_count", 64'(fifo_count), 64'd0);
        check("x0_pend",  64'(pend),       64'd0);

        // Re-issue to x7 in the cycle its queued result drains
        step(); iss_mark = 1; iss_rd = 7;
        step(); idle(); mc_valid = 1; mc_rd = 7; mc_data = 64'h77;
        step(); idle(); iss_mark = 1; iss_rd = 7;
        @(negedge clk);
        check("x7_drain_addr", 64'(write_addr), 64'd7);
        step(); idle();
        @(negedge clk);
        check("x7_pend_kept", 64'(pend), 64'h80);

        // Reset mid-operation with two queued entries and pend = 0x86
        step(); iss_mark = 1; iss_rd = 1;
        step(); iss_rd = 2;
        step(); idle(); pipe_we = 1; pipe_rd = 3; pipe_data = 64'h3;
        mc_valid = 1; mc_rd = 1; mc_data = 64'h11;
        step(); mc_rd = 2; mc_data = 64'h22;
        step(); mc_valid = 0; mc_rd = 0; mc_data = 0;
        @(negedge clk);
        check("pre_rst_count", 64'(fifo_count), 64'd2);
        check("pre_rst_pend",  64'(pend),       64'h86);
        #2 rst_n = 0;
        #1;
        check("async_we",    64'(we),         64'd0);
        check("async_addr",  64'(write_addr), 64'd0);
        check("async_data",  write_data,      64'd0);
        check("async_count", 64'(fifo_count), 64'd0);
        check("async_pend",  64'(pend),       64'd0);
        check("async_ready", 64'(mc_ready),   64'd0);
        check("async_stall", 64'(wb_stall),   64'd0);
        step(); idle(); rst_n = 1;
        @(negedge clk);
        check("rerst_ready", 64'(mc_ready), 64'd1);
        check("rerst_we",    64'(we),       64'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
